// File: rtl/cfi_mailbox_pkg.sv
// cfi_mailbox_pkg: shared constants, FSM state types and decode helpers for the
// CFI mailbox. Optional feature macro: CFI_MAILBOX_STATS_EN (completion counter).
package cfi_mailbox_pkg;

  // Byte offsets inside the 64-byte mailbox window
  localparam logic [5:0] CFI_MBOX_DATA_OFF  = 6'h00;
  localparam logic [5:0] CFI_MBOX_DB_OFF    = 6'h20;
  localparam logic [5:0] CFI_MBOX_CPL_OFF   = 6'h28;
  localparam logic [5:0] CFI_MBOX_STATS_OFF = 6'h30;

  // 64-bit word indices derived from the byte offsets
  localparam logic [2:0] CFI_MBOX_DB_IDX    = 3'(CFI_MBOX_DB_OFF >> 3);
  localparam logic [2:0] CFI_MBOX_CPL_IDX   = 3'(CFI_MBOX_CPL_OFF >> 3);
  localparam logic [2:0] CFI_MBOX_STATS_IDX = 3'(CFI_MBOX_STATS_OFF >> 3);

  // AXI response codes
  localparam logic [1:0] CFI_MBOX_RESP_OKAY   = 2'b00;
  localparam logic [1:0] CFI_MBOX_RESP_SLVERR = 2'b10;
  localparam logic [1:0] CFI_MBOX_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } cfi_mbox_wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } cfi_mbox_rstate_e;

  // True when a word index maps to an implemented register
  function automatic logic cfi_mbox_idx_valid(input logic [2:0] idx,
                                              input int unsigned nr_words);
    return (32'(idx) < nr_words) || (idx == CFI_MBOX_DB_IDX) ||
           (idx == CFI_MBOX_CPL_IDX) || (idx == CFI_MBOX_STATS_IDX);
  endfunction

  // Byte-lane merge of new write data into an old register value
  function automatic logic [63:0] cfi_mbox_merge(input logic [63:0] old_v,
                                                 input logic [63:0] new_v,
                                                 input logic [7:0]  strb);
    logic [63:0] v;
    v = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/cfi_mailbox_regs.sv
// cfi_mailbox_regs: DATA words, doorbell-pending flag, completion flag and the
// optional completion counter (CFI_MAILBOX_STATS_EN). Arbitrates the AXI write
// beat against the RoT completion write; both are judged against the current
// pending flag, so a same-cycle doorbell sees pending=1 and is refused.
module cfi_mailbox_regs
  import cfi_mailbox_pkg::*;
#(
  parameter int unsigned NR_DATA_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // AXI write beat (already decoded to a valid single-beat write)
  input  logic        i_axi_we,
  input  logic [2:0]  i_axi_idx,
  input  logic [63:0] i_axi_wdata,
  input  logic [7:0]  i_axi_wstrb,
  output logic        o_axi_err,
  // RoT write
  input  logic        i_rot_we,
  input  logic [2:0]  i_rot_idx,
  input  logic        i_rot_wbit,
  // Read ports
  input  logic [2:0]  i_axi_rd_idx,
  output logic [63:0] o_axi_rd_data,
  input  logic [2:0]  i_rot_rd_idx,
  output logic [63:0] o_rot_rd_data,
  // Status
  output logic        o_db_pending,
  output logic        o_completion
);

  logic [63:0] r_data [NR_DATA_WORDS];
  logic        r_db_pending;
  logic        r_completion;
  logic [63:0] w_stats;
  logic        w_data_wr;
  logic        w_db_wr;
  logic        w_db_set;
  logic        w_rot_cpl;

  assign w_data_wr = i_axi_we && (32'(i_axi_idx) < NR_DATA_WORDS);
  assign w_db_wr   = i_axi_we && (i_axi_idx == CFI_MBOX_DB_IDX) && i_axi_wdata[0];
  assign o_axi_err = (w_data_wr || w_db_wr) && r_db_pending;
  assign w_db_set  = w_db_wr && !r_db_pending;
  assign w_rot_cpl = i_rot_we && (i_rot_idx == CFI_MBOX_CPL_IDX) && i_rot_wbit &&
                     r_db_pending;

  // DATA words: byte-masked update only while no log is pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_DATA_WORDS; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < NR_DATA_WORDS; i++) begin
        if (w_data_wr && !r_db_pending && (i_axi_idx == 3'(i))) begin
          r_data[i] <= cfi_mbox_merge(r_data[i], i_axi_wdata, i_axi_wstrb);
        end
      end
    end
  end

  // Doorbell/completion handshake flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db_pending <= 1'b0;
      r_completion <= 1'b0;
    end else if (w_rot_cpl) begin
      r_db_pending <= 1'b0;
      r_completion <= 1'b1;
    end else if (w_db_set) begin
      r_db_pending <= 1'b1;
      r_completion <= 1'b0;
    end
  end

`ifdef CFI_MAILBOX_STATS_EN
  logic [31:0] r_stats;

  // Completed-transfer counter, wraps naturally at 32 bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stats <= '0;
    else if (w_rot_cpl) r_stats <= r_stats + 32'd1;
  end

  assign w_stats = {32'b0, r_stats};
`else
  assign w_stats = 64'b0;
`endif

  // Shared read map; reserved indices read as zero
  function automatic logic [63:0] rd_word(input logic [2:0] idx);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NR_DATA_WORDS; i++) begin
      if (idx == 3'(i)) v = r_data[i];
    end
    if (idx == CFI_MBOX_DB_IDX)    v = {63'b0, r_db_pending};
    if (idx == CFI_MBOX_CPL_IDX)   v = {63'b0, r_completion};
    if (idx == CFI_MBOX_STATS_IDX) v = w_stats;
    return v;
  endfunction

  assign o_axi_rd_data = rd_word(i_axi_rd_idx);
  assign o_rot_rd_data = rd_word(i_rot_rd_idx);
  assign o_db_pending  = r_db_pending;
  assign o_completion  = r_completion;

endmodule

// File: rtl/cfi_mailbox.sv
// cfi_mailbox: AXI4 slave mailbox terminating the CFI stage log port, with a
// RoT register port and doorbell/completion interrupts. Independent write
// (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_RESP) FSMs; state exposed on
// o_dbg_wstate / o_dbg_rstate. Optional macro: CFI_MAILBOX_STATS_EN.
// Handshakes: a channel transfer happens on a rising clock edge where both
// valid and ready are 1; valid, once raised by the mailbox, is held with stable
// payload until ready is seen.
module cfi_mailbox
  import cfi_mailbox_pkg::*;
#(
  parameter logic [63:0] MAILBOX_ADDR = 64'h1040_4000,
  parameter int unsigned XFER_SIZE    = 32,
  parameter int unsigned ARB_ID_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // AXI write address
  input  logic [ARB_ID_WIDTH-1:0] axi_awid_i,
  input  logic [63:0]             axi_awaddr_i,
  input  logic [7:0]              axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  // AXI write data
  input  logic [63:0]             axi_wdata_i,
  input  logic [7:0]              axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  // AXI write response
  output logic [ARB_ID_WIDTH-1:0] axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  // AXI read address
  input  logic [ARB_ID_WIDTH-1:0] axi_arid_i,
  input  logic [63:0]             axi_araddr_i,
  input  logic [7:0]              axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  // AXI read data
  output logic [ARB_ID_WIDTH-1:0] axi_rid_o,
  output logic [63:0]             axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  // RoT register port
  input  logic                    rot_req_i,
  input  logic                    rot_we_i,
  input  logic [5:0]              rot_addr_i,
  input  logic [63:0]             rot_wdata_i,
  output logic [63:0]             rot_rdata_o,
  output logic                    rot_rvalid_o,
  // Interrupts
  output logic                    doorbell_irq_o,
  output logic                    completion_irq_o,
  // Debug
  output logic [1:0]              o_dbg_wstate,
  output logic                    o_dbg_rstate
);

  localparam int unsigned NR_DATA_WORDS = XFER_SIZE / 8;

  cfi_mbox_wstate_e        r_wstate, w_wstate_next;
  cfi_mbox_rstate_e        r_rstate, w_rstate_next;
  logic                    r_init;
  logic [ARB_ID_WIDTH-1:0] r_bid;
  logic [2:0]              r_awidx;
  logic [1:0]              r_bresp;
  logic [ARB_ID_WIDTH-1:0] r_rid;
  logic [63:0]             r_rdata;
  logic [1:0]              r_rresp;
  logic [7:0]              r_rbeats;
  logic [63:0]             r_rot_rdata;
  logic                    r_rot_rvalid;

  logic [63:0] w_aw_off;
  logic [63:0] w_ar_off;
  logic        w_aw_hit;
  logic        w_ar_hit;
  logic        w_reg_we;
  logic        w_reg_err;
  logic [63:0] w_axi_rd_data;
  logic [63:0] w_rot_rd_data;
  logic        w_db_pending;
  logic        w_completion;
  logic        w_unused_ok;

  assign w_aw_off = axi_awaddr_i - MAILBOX_ADDR;
  assign w_ar_off = axi_araddr_i - MAILBOX_ADDR;
  assign w_aw_hit = (w_aw_off < 64'd64) && cfi_mbox_idx_valid(w_aw_off[5:3], NR_DATA_WORDS);
  assign w_ar_hit = (w_ar_off < 64'd64) && cfi_mbox_idx_valid(w_ar_off[5:3], NR_DATA_WORDS);
  assign w_unused_ok = ^{w_aw_off[2:0], w_ar_off[2:0], rot_addr_i[2:0], rot_wdata_i[63:1]};

  // Ready outputs stay low until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_init <= 1'b0;
    else         r_init <= 1'b1;
  end

  // Write and read FSM state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  // Write FSM next state and channel outputs
  always_comb begin
    w_wstate_next = r_wstate;
    axi_awready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    w_reg_we      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        axi_awready_o = r_init;
        if (r_init && axi_awvalid_i) w_wstate_next = W_DATA;
      end
      W_DATA: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i && axi_wlast_i) begin
          w_reg_we      = (r_bresp == CFI_MBOX_RESP_OKAY);
          w_wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Write transaction context: id, target word and response code
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bid   <= '0;
      r_awidx <= '0;
      r_bresp <= CFI_MBOX_RESP_OKAY;
    end else if (axi_awready_o && axi_awvalid_i) begin
      r_bid   <= axi_awid_i;
      r_awidx <= w_aw_off[5:3];
      if (!w_aw_hit)              r_bresp <= CFI_MBOX_RESP_DECERR;
      else if (axi_awlen_i != '0) r_bresp <= CFI_MBOX_RESP_SLVERR;
      else                        r_bresp <= CFI_MBOX_RESP_OKAY;
    end else if (w_reg_we && w_reg_err) begin
      r_bresp <= CFI_MBOX_RESP_SLVERR;
    end
  end

  assign axi_bid_o   = r_bid;
  assign axi_bresp_o = r_bresp;

  // Read FSM next state and channel outputs
  always_comb begin
    w_rstate_next = r_rstate;
    axi_arready_o = 1'b0;
    axi_rvalid_o  = 1'b0;
    axi_rlast_o   = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        axi_arready_o = r_init;
        if (r_init && axi_arvalid_i) w_rstate_next = R_RESP;
      end
      R_RESP: begin
        axi_rvalid_o = 1'b1;
        axi_rlast_o  = (r_rbeats == '0);
        if (axi_rready_i && (r_rbeats == '0)) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Read response capture and burst beat countdown
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= CFI_MBOX_RESP_OKAY;
      r_rbeats <= '0;
    end else if (axi_arready_o && axi_arvalid_i) begin
      r_rid    <= axi_arid_i;
      r_rbeats <= axi_arlen_i;
      if (!w_ar_hit) begin
        r_rresp <= CFI_MBOX_RESP_DECERR;
        r_rdata <= '0;
      end else if (axi_arlen_i != '0) begin
        r_rresp <= CFI_MBOX_RESP_SLVERR;
        r_rdata <= '0;
      end else begin
        r_rresp <= CFI_MBOX_RESP_OKAY;
        r_rdata <= w_axi_rd_data;
      end
    end else if (axi_rvalid_o && axi_rready_i && (r_rbeats != '0)) begin
      r_rbeats <= r_rbeats - 8'd1;
    end
  end

  assign axi_rid_o   = r_rid;
  assign axi_rdata_o = r_rdata;
  assign axi_rresp_o = r_rresp;

  // RoT read data returned one cycle after the request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rot_rvalid <= 1'b0;
      r_rot_rdata  <= '0;
    end else begin
      r_rot_rvalid <= rot_req_i && !rot_we_i;
      if (rot_req_i && !rot_we_i) r_rot_rdata <= w_rot_rd_data;
    end
  end

  assign rot_rvalid_o     = r_rot_rvalid;
  assign rot_rdata_o      = r_rot_rdata;
  assign doorbell_irq_o   = w_db_pending;
  assign completion_irq_o = w_completion;
  assign o_dbg_wstate     = r_wstate;
  assign o_dbg_rstate     = r_rstate;

  cfi_mailbox_regs #(
    .NR_DATA_WORDS (NR_DATA_WORDS)
  ) u_regs (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_axi_we      (w_reg_we),
    .i_axi_idx     (r_awidx),
    .i_axi_wdata   (axi_wdata_i),
    .i_axi_wstrb   (axi_wstrb_i),
    .o_axi_err     (w_reg_err),
    .i_rot_we      (rot_req_i && rot_we_i),
    .i_rot_idx     (rot_addr_i[5:3]),
    .i_rot_wbit    (rot_wdata_i[0]),
    .i_axi_rd_idx  (w_ar_off[5:3]),
    .o_axi_rd_data (w_axi_rd_data),
    .i_rot_rd_idx  (rot_addr_i[5:3]),
    .o_rot_rd_data (w_rot_rd_data),
    .o_db_pending  (w_db_pending),
    .o_completion  (w_completion)
  );

endmodule

// File: tb/tb_cfi_mailbox.sv
// tb_cfi_mailbox: directed bench for cfi_mailbox. Build with or without
// +define+CFI_MAILBOX_STATS_EN; the STATS expectation follows the macro.
module tb_cfi_mailbox;

  localparam logic [63:0] BASE = 64'h1040_4000;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam int          TMO  = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  awid = '0, bid, arid = '0, rid;
  logic [63:0] awaddr = '0, wdata = '0, araddr = '0, rdata, rot_wdata = '0, rot_rdata;
  logic [7:0]  awlen = '0, wstrb = '0, arlen = '0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic        rot_req = 1'b0, rot_we = 1'b0, rot_rvalid, db_irq, cpl_irq;
  logic [5:0]  rot_addr = '0;
  logic [1:0]  dbg_wstate;
  logic        dbg_rstate;

  cfi_mailbox #(.MAILBOX_ADDR(BASE), .XFER_SIZE(32), .ARB_ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .rot_req_i(rot_req), .rot_we_i(rot_we), .rot_addr_i(rot_addr),
    .rot_wdata_i(rot_wdata), .rot_rdata_o(rot_rdata), .rot_rvalid_o(rot_rvalid),
    .doorbell_irq_o(db_irq), .completion_irq_o(cpl_irq),
    .o_dbg_wstate(dbg_wstate), .o_dbg_rstate(dbg_rstate)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", tag, TMO);
  endtask

  // ---------------- driver tasks (all start and end just after a negedge) ----------------
  task automatic aw_phase(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    int t = 0;
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("aw_handshake");
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
    int t = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("w_handshake");
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(output logic [1:0] resp, output logic [3:0] id);
    int t = 0;
    bready = 1'b1;
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("b_handshake");
    resp = bresp; id = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [63:0] d,
                           input logic [7:0] s, output logic [1:0] resp);
    logic [3:0] id;
    aw_phase(addr, 8'd0, 4'h3);
    w_beat(d, s, 1'b1);
    b_phase(resp, id);
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len,
                          output logic [63:0] d, output logic [1:0] resp,
                          output logic last, output int beats, output logic [63:0] d_or);
    int t = 0;
    araddr = addr; arlen = len; arid = 4'h5; arvalid = 1'b1;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("ar_handshake");
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    beats = 0; d_or = '0; last = 1'b0; d = '0; resp = '0;
    t = 0;
    while (!last && t < TMO) begin
      if (rvalid) begin
        d = rdata; resp = rresp; last = rlast; beats++; d_or |= rdata;
      end
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout("r_handshake");
    rready = 1'b0;
  endtask

  task automatic rot_read(input logic [5:0] off, output logic [63:0] d, output logic v);
    rot_req = 1'b1; rot_we = 1'b0; rot_addr = off;
    @(negedge clk);
    rot_req = 1'b0;
    d = rot_rdata; v = rot_rvalid;
  endtask

  task automatic rot_write(input logic [5:0] off, input logic [63:0] d);
    rot_req = 1'b1; rot_we = 1'b1; rot_addr = off; rot_wdata = d;
    @(negedge clk);
    rot_req = 1'b0; rot_we = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]  resp;
    logic [3:0]  id;
    logic [63:0] d, d_or, exp_stats;
    logic        v, last;
    int          beats;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {63'b0, awready}, 64'd0);
    check("rst_arready", {63'b0, arready}, 64'd0);
    check("rst_bvalid",  {63'b0, bvalid},  64'd0);
    check("rst_rvalid",  {63'b0, rvalid},  64'd0);
    check("rst_rot_rvalid", {63'b0, rot_rvalid}, 64'd0);
    check("rst_db_irq",  {63'b0, db_irq},  64'd0);
    check("rst_cpl_irq", {63'b0, cpl_irq}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", {63'b0, awready}, 64'd1);

    // Fill DATA[0..3] then ring the doorbell
    exp_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    for (int i = 0; i < 4; i++) begin
      axi_write(BASE + 64'(i * 8), exp_q[i], 8'hFF, resp);
      check($sformatf("data%0d_bresp", i), {62'b0, resp}, {62'b0, OKAY});
    end
    aw_phase(BASE + 64'h20, 8'd0, 4'hA);
    w_beat(64'h1, 8'hFF, 1'b1);
    b_phase(resp, id);
    check("db_bresp", {62'b0, resp}, {62'b0, OKAY});
    check("db_bid",   {60'b0, id},   64'hA);
    check("db_irq_set",  {63'b0, db_irq},  64'd1);
    check("cpl_irq_low", {63'b0, cpl_irq}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      rot_read(6'(i * 8), d, v);
      check($sformatf("rot_rvalid%0d", i), {63'b0, v}, 64'd1);
      check($sformatf("rot_data%0d", i), d, exp_q.pop_front());
    end
    @(negedge clk);
    check("rot_rvalid_pulse", {63'b0, rot_rvalid}, 64'd0);

    // Writes refused while a log is pending
    axi_write(BASE + 64'h08, 64'hDEAD, 8'hFF, resp);
    check("data_pending_bresp", {62'b0, resp}, {62'b0, SLVERR});
    rot_read(6'h08, d, v);
    check("data_pending_unchanged", d, 64'h22);
    axi_write(BASE + 64'h20, 64'h1, 8'hFF, resp);
    check("db_twice_bresp", {62'b0, resp}, {62'b0, SLVERR});
    axi_read(BASE + 64'h20, 8'd0, d, resp, last, beats, d_or);
    check("axi_rd_db", d, 64'd1);
    check("axi_rd_db_resp", {62'b0, resp}, {62'b0, OKAY});

    // RoT completion, then byte-masked write and a fresh doorbell
    rot_write(6'h28, 64'h1);
    check("cpl_db_irq", {63'b0, db_irq},  64'd0);
    check("cpl_cpl_irq", {63'b0, cpl_irq}, 64'd1);
    axi_write(BASE + 64'h08, 64'h0000_AB00, 8'h02, resp);
    check("strb_bresp", {62'b0, resp}, {62'b0, OKAY});
    axi_read(BASE + 64'h08, 8'd0, d, resp, last, beats, d_or);
    check("strb_data", d, 64'hAB22);
    axi_write(BASE + 64'h20, 64'h1, 8'hFF, resp);
    check("db2_bresp", {62'b0, resp}, {62'b0, OKAY});
    check("db2_cpl_cleared", {63'b0, cpl_irq}, 64'd0);
    check("db2_db_irq", {63'b0, db_irq}, 64'd1);

    // Burst write, decode errors, burst read
    aw_phase(BASE, 8'd3, 4'h1);
    for (int i = 0; i < 4; i++) w_beat(64'h99, 8'hFF, i == 3);
    b_phase(resp, id);
    check("burst_w_bresp", {62'b0, resp}, {62'b0, SLVERR});
    rot_read(6'h00, d, v);
    check("burst_w_unchanged", d, 64'h11);
    axi_read(BASE + 64'h40, 8'd0, d, resp, last, beats, d_or);
    check("oow_rresp", {62'b0, resp}, {62'b0, DECERR});
    check("oow_rlast", {63'b0, last}, 64'd1);
    check("oow_rdata", d, 64'd0);
    axi_write(BASE + 64'h38, 64'h5, 8'hFF, resp);
    check("rsvd_bresp", {62'b0, resp}, {62'b0, DECERR});
    axi_read(BASE, 8'd1, d, resp, last, beats, d_or);
    check("burst_r_beats", 64'(beats), 64'd2);
    check("burst_r_resp", {62'b0, resp}, {62'b0, SLVERR});
    check("burst_r_zero", d_or, 64'd0);

    // AXI doorbell beat and RoT completion on the same edge
    aw_phase(BASE + 64'h20, 8'd0, 4'h2);
    wdata = 64'h1; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    rot_req = 1'b1; rot_we = 1'b1; rot_addr = 6'h28; rot_wdata = 64'h1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; rot_req = 1'b0; rot_we = 1'b0;
    b_phase(resp, id);
    check("race_bresp", {62'b0, resp}, {62'b0, SLVERR});
    check("race_db_irq", {63'b0, db_irq}, 64'd0);
    check("race_cpl_irq", {63'b0, cpl_irq}, 64'd1);
    rot_read(6'h20, d, v);
    check("race_rot_db", d, 64'd0);

    // Reset in the middle of a burst: no response afterwards
    aw_phase(BASE, 8'd3, 4'h4);
    w_beat(64'h77, 8'hFF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", {63'b0, bvalid}, 64'd0);
    check("midrst_awready", {63'b0, awready}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle", {63'b0, awready}, 64'd1);
    check("midrst_no_b", {63'b0, bvalid}, 64'd0);
    check("midrst_cpl", {63'b0, cpl_irq}, 64'd0);
    rot_read(6'h00, d, v);
    check("midrst_data0", d, 64'd0);

    // Three complete transfers, then STATS
    for (int i = 0; i < 3; i++) begin
      axi_write(BASE, 64'(i + 1), 8'hFF, resp);
      check($sformatf("xfer%0d_data", i), {62'b0, resp}, {62'b0, OKAY});
      axi_write(BASE + 64'h20, 64'h1, 8'hFF, resp);
      check($sformatf("xfer%0d_db", i), {62'b0, resp}, {62'b0, OKAY});
      rot_write(6'h28, 64'h1);
      check($sformatf("xfer%0d_cpl", i), {63'b0, cpl_irq}, 64'd1);
    end
`ifdef CFI_MAILBOX_STATS_EN
    exp_stats = 64'd3;
`else
    exp_stats = 64'd0;
`endif
    rot_read(6'h30, d, v);
    check("rot_stats", d, exp_stats);
    axi_read(BASE + 64'h30, 8'd0, d, resp, last, beats, d_or);
    check("axi_stats", d, exp_stats);
    check("axi_stats_resp", {62'b0, resp}, {62'b0, OKAY});

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfi_mailbox.md
Name: cfi_mailbox

Overview:
- AXI4 slave mailbox directly downstream of the CFI stage; terminates the CFI AXI master port (log data words plus doorbell).
- Exposes received logs to the Root-of-Trust (RoT) through a simple register port.
- Returns the completion interrupt that the CFI stage consumes on its mbox_completion_irq_i input.
- One instance per core, on the SoC AXI crossbar at the CFI mailbox address window.

Parameters:
- MAILBOX_ADDR, 'h10404000, base of the 64-byte window (riscv::VLEN bits).
- XFER_SIZE, 32, bytes of log payload per transfer; NR_DATA_WORDS = XFER_SIZE/8, must be 1..4.
- ARB_ID_WIDTH, ariane_soc::IdWidth, AXI ID width; the ID is echoed.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- axi_req_i  in  ariane_axi::req_t  AXI4 request from the CFI stage
- axi_resp_o  out  ariane_axi::resp_t  AXI4 response
- rot_req_i  in  1  RoT register access strobe
- rot_we_i  in  1  RoT write enable
- rot_addr_i  in  6  RoT byte offset
- rot_wdata_i  in  64  RoT write data
- rot_rdata_o  out  64  RoT read data
- rot_rvalid_o  out  1  RoT read data valid, one cycle after rot_req_i
- doorbell_irq_o  out  1  level interrupt to RoT: log pending
- completion_irq_o  out  1  level interrupt to the CFI stage: RoT finished

Behaviour:
- Offset map (AXI offset = addr - MAILBOX_ADDR):
  - 0x00..0x18: DATA[0..3]; index >= NR_DATA_WORDS is reserved.
  - 0x20: DOORBELL.
  - 0x28: COMPLETION.
  - 0x30: STATS.
- Reset: all AXI ready/valid outputs 0, rot_rvalid_o 0, doorbell_irq_o 0, completion_irq_o 0, DATA 0, db_pending 0.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1; on AW handshake, latch id, addr and len; go to W_DATA.
  - W_DATA: wready=1; each beat is checked; on wlast go to W_RESP.
  - W_RESP: bvalid=1 with latched id; hold until bready; then go to W_IDLE.
- Write checks:
  - len!=0: all beats drained, bresp=SLVERR, no register update.
  - Address outside the window or a reserved offset: DECERR.
- DATA write while db_pending=1: SLVERR, data unchanged. Otherwise a byte-masked update by wstrb, OKAY.
- DOORBELL write with wdata[0]=1:
  - If db_pending=0: set db_pending, clear completion_irq_o, OKAY.
  - If db_pending=1: SLVERR.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready=1 on AR handshake.
  - R_RESP: rvalid=1, rlast=1, id echoed; held until rready.
  - Response latency: 1 cycle minimum.
- AXI readback: DATA, {63'b0, db_pending} at DOORBELL, {63'b0, completion_irq_o} at COMPLETION, STATS. Bursts give SLVERR with len+1 beats of zero data.
- Read and write FSMs are independent; they may be active in the same cycle.
- doorbell_irq_o = db_pending.
- RoT port:
  - Reads return the same map as AXI readback; rot_rvalid_o pulses one cycle after each read.
  - Write to COMPLETION with bit0=1 while db_pending=1: clear db_pending, set completion_irq_o.
  - Any other RoT write is ignored.
- Simultaneous AXI DOORBELL write and RoT COMPLETION in the same cycle: the completion takes effect and the doorbell gets SLVERR, because it was evaluated against pending=1.
- A reset mid-burst drops the transaction; no response is issued.

Optional Feature:
- Macro: CFI_MAILBOX_STATS_EN.
- Defined: a 32-bit counter of completed transfers increments on each accepted RoT completion, wraps 0xFFFFFFFF->0, and is readable zero-extended at STATS on both ports.
- Undefined: STATS reads 0 and no counter flops exist.

Decomposition:
- ariane_pkg gets the offset constants CFI_MBOX_DATA_OFF, CFI_MBOX_DB_OFF, CFI_MBOX_CPL_OFF and CFI_MBOX_STATS_OFF, plus the cfi_mbox_wstate_e and cfi_mbox_rstate_e enums.
- One sub-module, cfi_mailbox_regs: the DATA/db_pending/completion/stats storage with write-port arbitration. The top level holds the AXI FSMs.

Test Plan:
- Four single-beat writes of DATA 0x11..0x44 to 0x00..0x18, then DOORBELL=1 -> five OKAY bresp, doorbell_irq_o=1 the cycle after the last B, RoT reads return 0x11..0x44.
- RoT writes COMPLETION=1 -> doorbell_irq_o=0 and completion_irq_o=1 next cycle; the next AXI DOORBELL write clears completion_irq_o.
- DATA write to 0x08 while pending -> SLVERR, RoT read of 0x08 is unchanged; a second DOORBELL write while pending -> SLVERR.
- AW with len=3 to 0x00 -> 4 beats accepted, single SLVERR, DATA unchanged; AR to MAILBOX_ADDR+0x40 -> DECERR with rlast=1.
- AXI DOORBELL write and RoT completion in the same cycle -> SLVERR, db_pending=0, completion_irq_o=1.
- With CFI_MAILBOX_STATS_EN: 3 full transfer cycles -> STATS reads 3. Without the macro -> STATS reads 0.
